// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared state encoding and channel geometry for the scan sequencer
package scan_seq_pkg;
    localparam int NUM_CH = 16;
    localparam int IDX_W  = 4;
    typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;
endpackage

// File: rtl/scan_dwell_timer.sv
// scan_dwell_timer: loadable down-counter timing the on-period of one channel
module scan_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;
    // load on DWELL entry, then count down and rest at zero
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign expired = cnt == '0;
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 4-to-16 decoder over masked channels; SCAN_FRAME_CNT_EN adds frame_count
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  mask,
    output logic               en416,
    output logic               d,
    output logic               c,
    output logic               b,
    output logic               a,
    output logic               busy,
    output logic               frame_done
`ifdef SCAN_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_count
`endif
);
    state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic load, expired, wrap, accept;
    scan_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk(clk), .rst(rst), .load(load), .value(dwell), .expired(expired)
    );
    assign {d, c, b, a} = idx;
    // next state and index; stop overrides everything and freezes idx
    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        wrap    = 1'b0;
        accept  = !stop && state == IDLE && start && mask != '0;
        if (stop) state_n = IDLE;
        else case (state)
            IDLE: if (accept) begin
                state_n = SEEK;
                idx_n   = '0;
            end
            SEEK: if (mask == '0) state_n = IDLE;
            else if (mask[idx]) begin
                state_n = DWELL;
                load    = 1'b1;
            end else begin
                idx_n = idx + 1'b1;
                wrap  = &idx;
            end
            DWELL: if (expired) begin
                state_n = SEEK;
                idx_n   = idx + 1'b1;
                wrap    = &idx;
            end
            default: state_n = IDLE;
        endcase
    end
    // state, index and registered outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            en416      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            en416      <= state_n == DWELL;
            busy       <= state_n != IDLE;
            frame_done <= wrap;
        end
`ifdef SCAN_FRAME_CNT_EN
    // frames completed since the last accepted start
    always_ff @(posedge clk or posedge rst)
        if (rst) frame_count <= '0;
        else if (accept) frame_count <= '0;
        else if (wrap) frame_count <= frame_count + 1'b1;
`endif
endmodule
